// File: rtl/sa_ctrl_pkg.sv
// Shared types and phase-length helpers for the systolic-array pass sequencer.
package sa_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_W  = 3'd1,
        LOAD_A  = 3'd2,
        FILL    = 3'd3,
        DRAIN   = 3'd4,
        READOUT = 3'd5,
        DONE    = 3'd6
    } sa_state_e;

    function automatic int unsigned len_load_w(input int unsigned h);
        return h;
    endfunction

    function automatic int unsigned len_load_a(input int unsigned h);
        return h;
    endfunction

    function automatic int unsigned len_fill(input int unsigned w);
        return w - 32'd1;
    endfunction

    function automatic int unsigned len_drain(input int unsigned h);
        return 32'd2 * h;
    endfunction

    function automatic int unsigned len_readout(input int unsigned h);
        return h;
    endfunction

    // Wide enough to hold the longest phase (DRAIN, 2H cycles).
    function automatic int unsigned cnt_width(input int unsigned h);
        return $clog2(32'd2 * h + 32'd1);
    endfunction

    function automatic int unsigned row_width(input int unsigned h);
        return (h < 32'd2) ? 32'd1 : $clog2(h);
    endfunction

endpackage

// File: rtl/sa_phase_counter.sv
// Loadable down-counter with count enable and zero flag; load wins over enable.
module sa_phase_counter
    import sa_ctrl_pkg::*;
#(
    parameter int WIDTH = 32'd4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Next count: saturate at zero rather than wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign count_o = cnt_q;
    assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/sa_seq_ctrl.sv
// One-pass sequencer for the systolic array: drives buffer/PE enables phase by phase
// from a single shared phase counter.
module sa_seq_ctrl
    import sa_ctrl_pkg::*;
#(
    parameter int ARRAYHEIGHT = 32'd4,
    parameter int ARRAYWIDTH  = 32'd4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                out_ready,
    output logic                                busy,
    output logic                                done,
    output logic [row_width(ARRAYHEIGHT)-1:0]   row_idx,
    output logic                                weight_buffer_load_en,
    output logic                                weight_buffer_out_en,
    output logic                                write_weight_en,
    output logic                                input_buffer_load_en,
    output logic                                input_buffer_out_en,
    output logic                                output_buffer_load_en,
    output logic                                output_buffer_out_en
);

    localparam int CW        = cnt_width(ARRAYHEIGHT);
    localparam int RW        = row_width(ARRAYHEIGHT);
    localparam bit SKIP_FILL = (ARRAYWIDTH == 32'd1);

    // Counter load values are phase length minus one.
    localparam logic [CW-1:0] LD_W    = CW'(len_load_w(ARRAYHEIGHT) - 32'd1);
    localparam logic [CW-1:0] LD_A    = CW'(len_load_a(ARRAYHEIGHT) - 32'd1);
    localparam logic [CW-1:0] LD_FILL = SKIP_FILL ? '0 : CW'(len_fill(ARRAYWIDTH) - 32'd1);
    localparam logic [CW-1:0] LD_DR   = CW'(len_drain(ARRAYHEIGHT) - 32'd1);
    localparam logic [CW-1:0] LD_RD   = CW'(len_readout(ARRAYHEIGHT) - 32'd1);
    localparam logic [CW-1:0] H_M1    = CW'(ARRAYHEIGHT - 32'd1);

    sa_state_e        state_q;
    sa_state_e        state_d;
    logic             load_s;
    logic [CW-1:0]    load_val_s;
    logic             cnt_en_s;
    logic [CW-1:0]    count_s;
    logic             zero_s;
    logic [RW-1:0]    row_s;

    sa_phase_counter #(
        .WIDTH(CW)
    ) u_phase_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load_s),
        .load_val_i (load_val_s),
        .en_i       (cnt_en_s),
        .count_o    (count_s),
        .zero_o     (zero_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; every transition reloads the counter for the new phase.
    always_comb begin
        state_d    = state_q;
        load_s     = 1'b0;
        load_val_s = '0;
        cnt_en_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD_W;
                    load_s     = 1'b1;
                    load_val_s = LD_W;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD_W: begin
                cnt_en_s = 1'b1;
                if (zero_s) begin
                    state_d    = LOAD_A;
                    load_s     = 1'b1;
                    load_val_s = LD_A;
                end else begin
                    state_d = LOAD_W;
                end
            end
            LOAD_A: begin
                cnt_en_s = 1'b1;
                if (zero_s && SKIP_FILL) begin
                    state_d    = DRAIN;
                    load_s     = 1'b1;
                    load_val_s = LD_DR;
                end else if (zero_s) begin
                    state_d    = FILL;
                    load_s     = 1'b1;
                    load_val_s = LD_FILL;
                end else begin
                    state_d = LOAD_A;
                end
            end
            FILL: begin
                cnt_en_s = 1'b1;
                if (zero_s) begin
                    state_d    = DRAIN;
                    load_s     = 1'b1;
                    load_val_s = LD_DR;
                end else begin
                    state_d = FILL;
                end
            end
            DRAIN: begin
                cnt_en_s = 1'b1;
                if (zero_s) begin
                    state_d    = READOUT;
                    load_s     = 1'b1;
                    load_val_s = LD_RD;
                end else begin
                    state_d = DRAIN;
                end
            end
            READOUT: begin
                // Only accepted rows advance the readout.
                cnt_en_s = out_ready;
                if (zero_s && out_ready) begin
                    state_d    = DONE;
                    load_s     = 1'b1;
                    load_val_s = '0;
                end else begin
                    state_d = READOUT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d    = IDLE;
                load_s     = 1'b1;
                load_val_s = '0;
            end
        endcase
    end

    assign row_s = RW'(H_M1 - count_s);

    // Moore output decode; only output_buffer_out_en looks at out_ready.
    always_comb begin
        busy                  = 1'b1;
        done                  = 1'b0;
        row_idx               = '0;
        weight_buffer_load_en = 1'b0;
        weight_buffer_out_en  = 1'b0;
        write_weight_en       = 1'b0;
        input_buffer_load_en  = 1'b0;
        input_buffer_out_en   = 1'b0;
        output_buffer_load_en = 1'b0;
        output_buffer_out_en  = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
            end
            LOAD_W: begin
                weight_buffer_load_en = 1'b1;
                row_idx               = row_s;
            end
            LOAD_A: begin
                weight_buffer_out_en = 1'b1;
                write_weight_en      = 1'b1;
                input_buffer_load_en = 1'b1;
                row_idx              = row_s;
            end
            FILL: begin
                input_buffer_out_en = 1'b1;
            end
            DRAIN: begin
                input_buffer_out_en   = 1'b1;
                output_buffer_load_en = 1'b1;
            end
            READOUT: begin
                input_buffer_out_en  = 1'b1;
                output_buffer_out_en = out_ready;
                row_idx              = row_s;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sa_seq_ctrl.sv
// Self-checking bench for sa_seq_ctrl: directed vector table, corner sequences and
// randomized traffic checked against a timeline-based reference model.
module tb_sa_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: H=4, W=4.  DUT B: H=2, W=1.
    logic rst_a = 1'b1, start_a = 1'b0, ready_a = 1'b0;
    logic rst_b = 1'b1, start_b = 1'b0, ready_b = 1'b0;
    logic busy_a, done_a, wbl_a, wbo_a, wwe_a, ibl_a, ibo_a, obl_a, obo_a;
    logic busy_b, done_b, wbl_b, wbo_b, wwe_b, ibl_b, ibo_b, obl_b, obo_b;
    logic [1:0] row_a;
    logic [0:0] row_b;

    sa_seq_ctrl #(.ARRAYHEIGHT(4), .ARRAYWIDTH(4)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .out_ready(ready_a),
        .busy(busy_a), .done(done_a), .row_idx(row_a),
        .weight_buffer_load_en(wbl_a), .weight_buffer_out_en(wbo_a),
        .write_weight_en(wwe_a), .input_buffer_load_en(ibl_a),
        .input_buffer_out_en(ibo_a), .output_buffer_load_en(obl_a),
        .output_buffer_out_en(obo_a)
    );

    sa_seq_ctrl #(.ARRAYHEIGHT(2), .ARRAYWIDTH(1)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .out_ready(ready_b),
        .busy(busy_b), .done(done_b), .row_idx(row_b),
        .weight_buffer_load_en(wbl_b), .weight_buffer_out_en(wbo_b),
        .write_weight_en(wwe_b), .input_buffer_load_en(ibl_b),
        .input_buffer_out_en(ibo_b), .output_buffer_load_en(obl_b),
        .output_buffer_out_en(obo_b)
    );

    // Packed view: {busy,done,wbl,wbo,wwe,ibl,ibo,obl,obo, row[6:0]}
    logic [15:0] vec_a, vec_b;
    assign vec_a = {busy_a, done_a, wbl_a, wbo_a, wwe_a, ibl_a, ibo_a, obl_a, obo_a, 5'd0, row_a};
    assign vec_b = {busy_b, done_b, wbl_b, wbo_b, wwe_b, ibl_b, ibo_b, obl_b, obo_b, 6'd0, row_b};

    int n_tests = 0;
    int n_fail  = 0;
    int slot    = 0;

    // Per-sequence observations
    int done_cnt, done_slot, obl_cnt, obl_first, busy_cnt, st_n;
    int st_slot[4];
    bit prev_wbl;

    // Reference model: pass timeline (offset from first LOAD_W cycle, accepted rows)
    int  mh[2] = '{4, 2};
    int  mw[2] = '{4, 1};
    bit  m_act[2];
    int  m_off[2];
    int  m_rows[2];
    bit  m_done[2];

    function automatic logic [15:0] model_exp(input int id, input bit rd);
        int h = mh[id];
        int w = mw[id];
        int o = m_off[id];
        logic [8:0] f = 9'd0;
        int row = 0;
        if (m_done[id]) begin
            f = 9'b110000000;
        end else if (m_act[id]) begin
            f[8] = 1'b1;
            if (o < h) begin
                f[6] = 1'b1; row = o;
            end else if (o < 2*h) begin
                f[5] = 1'b1; f[4] = 1'b1; f[3] = 1'b1; row = o - h;
            end else if (o < 2*h + w - 1) begin
                f[2] = 1'b1;
            end else if (o < 4*h + w - 1) begin
                f[2] = 1'b1; f[1] = 1'b1;
            end else begin
                f[2] = 1'b1; f[0] = rd; row = m_rows[id];
            end
        end
        return {f, 7'(row)};
    endfunction

    task automatic model_step(input int id, input bit st, input bit rd, input bit rs);
        if (rs) begin
            m_act[id] = 1'b0; m_done[id] = 1'b0; m_off[id] = 0; m_rows[id] = 0;
        end else if (m_done[id]) begin
            m_done[id] = 1'b0;
        end else if (m_act[id]) begin
            if (m_off[id] >= 4*mh[id] + mw[id] - 1) begin
                if (rd) begin
                    m_rows[id]++;
                    if (m_rows[id] == mh[id]) begin
                        m_act[id] = 1'b0; m_done[id] = 1'b1;
                    end
                end
            end else begin
                m_off[id]++;
            end
        end else if (st) begin
            m_act[id] = 1'b1; m_off[id] = 0; m_rows[id] = 0;
        end
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s slot %0d: got %h expected %h", name, slot, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic seq_begin();
        slot = 0; done_cnt = 0; done_slot = -1; obl_cnt = 0; obl_first = -1;
        busy_cnt = 0; st_n = 0; prev_wbl = 1'b0;
        for (int i = 0; i < 4; i++) st_slot[i] = -1;
    endtask

    // One cycle: drive inputs at negedge, compare with model, advance model.
    task automatic tick(input int id, input bit st, input bit rd, input bit rs,
                        output logic [15:0] act);
        @(negedge clk);
        if (id == 0) begin
            start_a = st; ready_a = rd; rst_a = rs;
        end else begin
            start_b = st; ready_b = rd; rst_b = rs;
        end
        #1;
        act = (id == 0) ? vec_a : vec_b;
        check("model", act, model_exp(id, rd));
        if (act[14] === 1'b1) begin done_cnt++; done_slot = slot; end
        if (act[8] === 1'b1) begin
            obl_cnt++;
            if (obl_first < 0) obl_first = slot;
        end
        if (act[15] === 1'b1) busy_cnt++;
        if (act[13] === 1'b1 && !prev_wbl && st_n < 4) begin
            st_slot[st_n] = slot; st_n++;
        end
        prev_wbl = (act[13] === 1'b1);
        model_step(id, st, rd, rs);
        slot++;
    endtask

    typedef struct {
        int         lo;
        int         hi;
        bit         st;
        bit         rd;
        logic [8:0] flags;
        bit         rowstep;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [15:0] act;

        tbl[0] = '{0,  0,  1'b1, 1'b1, 9'b000000000, 1'b0};
        tbl[1] = '{1,  4,  1'b0, 1'b1, 9'b101000000, 1'b1};
        tbl[2] = '{5,  8,  1'b0, 1'b1, 9'b100111000, 1'b1};
        tbl[3] = '{9,  11, 1'b0, 1'b1, 9'b100000100, 1'b0};
        tbl[4] = '{12, 19, 1'b0, 1'b1, 9'b100000110, 1'b0};
        tbl[5] = '{20, 23, 1'b0, 1'b1, 9'b100000101, 1'b1};
        tbl[6] = '{24, 24, 1'b0, 1'b1, 9'b110000000, 1'b0};
        tbl[7] = '{25, 27, 1'b0, 1'b1, 9'b000000000, 1'b0};

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        #1;
        check("reset_a", vec_a, 16'h0000);
        check("reset_b", vec_b, 16'h0000);

        // Directed table: H=4 W=4 nominal pass
        seq_begin();
        for (int i = 0; i < 8; i++) begin
            for (int s = tbl[i].lo; s <= tbl[i].hi; s++) begin
                tick(0, tbl[i].st && (s == tbl[i].lo), tbl[i].rd, 1'b0, act);
                check("table", act, {tbl[i].flags, (tbl[i].rowstep ? 7'(s - tbl[i].lo) : 7'd0)});
            end
        end
        check_int("nominal_done_slot", done_slot, 24);

        // Stall on slots 21-22: row holds at 1, done moves to 26
        seq_begin();
        for (int s = 0; s < 30; s++) begin
            tick(0, s == 0, !(s == 21 || s == 22), 1'b0, act);
            if (s == 21 || s == 22) check("stall_row", {8'd0, act[7:0]}, 16'h0001);
        end
        check_int("stall_done_slot", done_slot, 26);
        check_int("stall_done_cnt", done_cnt, 1);

        // start held high: passes at 1, 26, 51 only
        seq_begin();
        for (int s = 0; s < 86; s++) tick(0, s < 61, 1'b1, 1'b0, act);
        check_int("held_pass_cnt", st_n, 3);
        check_int("held_start0", st_slot[0], 1);
        check_int("held_start1", st_slot[1], 26);
        check_int("held_start2", st_slot[2], 51);
        check_int("held_done_cnt", done_cnt, 3);

        // rst during DRAIN at slot 14
        seq_begin();
        for (int s = 0; s < 32; s++) begin
            tick(0, s == 0, 1'b1, s == 14, act);
            if (s == 15) check("rst_mid_zero", act, 16'h0000);
        end
        check_int("rst_mid_done_cnt", done_cnt, 0);

        // H=2 W=1: no FILL, DRAIN 5-8, READOUT 9-10, done 11
        seq_begin();
        for (int s = 0; s < 14; s++) begin
            tick(1, s == 0, 1'b1, 1'b0, act);
            if (s == 9) check("b_readout_row0", act, {9'b100000101, 7'd0});
            if (s == 10) check("b_readout_row1", act, {9'b100000101, 7'd1});
        end
        check_int("b_obl_first", obl_first, 5);
        check_int("b_obl_cnt", obl_cnt, 4);
        check_int("b_done_slot", done_slot, 11);

        // start pulsed while busy (slot 7) is ignored
        seq_begin();
        for (int s = 0; s < 41; s++) tick(0, s == 0 || s == 7, 1'b1, 1'b0, act);
        check_int("busy_start_done", done_slot, 24);
        check_int("busy_start_cnt", busy_cnt, 24);
        check_int("busy_start_passes", st_n, 1);

        // Randomized traffic against the model
        for (int s = 0; s < 3000; s++) begin
            tick(0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 299) == 0, act);
        end
        for (int s = 0; s < 2000; s++) begin
            tick(1, $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 299) == 0, act);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sa_seq_ctrl.md
# sa_seq_ctrl

Sequencer for one systolic-array matrix pass. On a start handshake it walks weight load, activation load, pipeline fill, output capture and result read-out, driving the buffer and PE enables of `top` with the cycle spacing the array needs. It also emits row indices for the host-side data source and a done pulse. It replaces free-running cycle-count enable decoding and sits between the host/DMA logic and `top`.

## Interface
- `ARRAYHEIGHT`, default 4: array rows H; also the row count of the weight, activation and result phases; must be at least 1.
- `ARRAYWIDTH`, default 4: array columns W; must be at least 1.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: request one pass; sampled only in IDLE.
- `out_ready` in 1: result consumer ready; honoured only in READOUT.
- `busy` out 1: high whenever state is not IDLE.
- `done` out 1: one-cycle pulse after the last result row is transferred.
- `row_idx` out clog2(max(H,2)): current row within LOAD_W, LOAD_A or READOUT; 0 in all other states.
- `weight_buffer_load_en` out 1: high in LOAD_W.
- `weight_buffer_out_en` out 1: high in LOAD_A.
- `write_weight_en` out 1: high in LOAD_A.
- `input_buffer_load_en` out 1: high in LOAD_A.
- `input_buffer_out_en` out 1: high in FILL, DRAIN and READOUT.
- `output_buffer_load_en` out 1: high in DRAIN.
- `output_buffer_out_en` out 1: high in READOUT when `out_ready` is high.

## Operation
- States and exits:
  - IDLE: go to LOAD_W when `start` is high.
  - LOAD_W: lasts H cycles, then LOAD_A.
  - LOAD_A: lasts H cycles, then FILL. If W=1, skip FILL and go straight to DRAIN.
  - FILL: lasts W-1 cycles, then DRAIN.
  - DRAIN: lasts 2H cycles, then READOUT.
  - READOUT: lasts H accepted cycles, then DONE.
  - DONE: lasts 1 cycle, then IDLE.
- A single phase counter is loaded with (phase length - 1) on state entry. It decrements each cycle and the state exits when it reaches 0.
- In READOUT the counter decrements only on cycles where `out_ready` is high.
- `row_idx` = H-1 minus the counter in LOAD_W, LOAD_A and READOUT. In READOUT it holds while `out_ready` is low.
- Enables are a Moore decode of the registered state; the only exception is the `out_ready` gating of `output_buffer_out_en`.
- `start` while `busy` is high, including in DONE, is ignored. Requests are not queued.
- `out_ready` outside READOUT has no effect.

## Timing
- Reset values: state IDLE, counter 0, every output 0.
- `rst` mid-pass: at the next edge all enables drop and the state returns to IDLE. No done pulse is issued.
- Start sampled at edge k: LOAD_W covers cycles k+1 to k+H.
- LOAD_A covers k+H+1 to k+2H.
- FILL covers k+2H+1 to k+2H+W-1.
- DRAIN covers k+2H+W to k+4H+W-1.
- READOUT starts at k+4H+W. With no stall, `done` is high at k+5H+W.
- Each stall cycle in READOUT delays `done` by exactly one cycle.
- Back-to-back passes: the earliest accepted `start` is in the IDLE cycle after DONE. The minimum period is 5H+W+1 cycles.

## Structure
- Shared package `sa_ctrl_pkg`:
  - state enum IDLE, LOAD_W, LOAD_A, FILL, DRAIN, READOUT, DONE;
  - localparam functions for the phase lengths H, H, W-1, 2H, H;
  - counter width clog2(2H+1).
- One sub-module, `sa_phase_counter`: a loadable down-counter with an enable and a zero flag. The FSM wrapper holds state, load values and output decode.

## Test plan
- H=4, W=4, start pulsed at edge 0, `out_ready` held at 1:
  - `weight_buffer_load_en` high in cycles 1–4;
  - load enables high in 5–8;
  - FILL in 9–11;
  - `output_buffer_load_en` high in 12–19;
  - `output_buffer_out_en` high in 20–23 with `row_idx` 0,1,2,3;
  - `done` high in cycle 24 and `busy` low in 25.
- Same setup with `out_ready` low in cycles 21–22: `output_buffer_out_en` is low in those cycles, `row_idx` holds at 1, and `done` moves to cycle 26.
- `start` held high continuously: passes begin at cycles 1, 26, 51, and no extra pass is started from DONE.
- `rst` asserted at cycle 14, during DRAIN: all outputs are 0 from cycle 15, the state is IDLE, and `done` never pulses.
- H=2, W=1: FILL is skipped, `output_buffer_load_en` is high in cycles 5–8, READOUT covers 9–10, and `done` is high in cycle 11.
- `start` pulsed while `busy` (cycle 7): the running pass timing is unchanged, and there is no second pass.
